// File: rtl/timer_port_arbiter.sv
// Arbitrates NR_REQ requester ports onto a single timer register port.
// Round-robin when unlocked; a granted requester may hold a lock that times out.
module timer_port_arbiter #(
  parameter int NR_REQ       = 2,
  parameter int ADDR_WIDTH   = 64,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NR_REQ-1:0]                   req_i,
  input  logic [NR_REQ-1:0]                   we_i,
  input  logic [NR_REQ-1:0]                   lock_i,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NR_REQ-1:0][63:0]             wdata_i,
  output logic [NR_REQ-1:0]                   gnt_o,
  output logic [NR_REQ-1:0]                   rvalid_o,
  output logic [63:0]                         rdata_o,
  output logic                                lock_err_o,
  output logic                                en_o,
  output logic                                we_o,
  output logic [ADDR_WIDTH-1:0]               address_o,
  output logic [63:0]                         wdata_o,
  input  logic [63:0]                         rdata_i
);

  localparam int IDX_W = $clog2(NR_REQ);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [7:0]         idle_q, idle_d;
  logic [IDX_W-1:0]   resp_idx_q;
  logic               resp_vld_q;
  logic [63:0]        rdata_q;
  logic               lock_err_q, lock_err_d;

  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NR_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    idle_d     = idle_q;
    lock_err_d = 1'b0;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    cand       = '0;

    unique case (state_q)
      UNLOCKED: begin
        for (int i = 0; i < NR_REQ; i++) begin
          cand = IDX_W'((int'(rr_q) + i) % NR_REQ);
          if (!gnt_vld && req_i[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
        if (gnt_vld) begin
          rr_d = next_idx(gnt_idx);
          if (lock_i[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
            idle_d  = '0;
          end
        end
      end
      LOCKED: begin
        // Non-owners stall, including the cycle in which the lock is released.
        if (req_i[owner_q]) begin
          gnt_vld = 1'b1;
          gnt_idx = owner_q;
          idle_d  = '0;
          if (!lock_i[owner_q]) begin
            state_d = UNLOCKED;
            rr_d    = next_idx(owner_q);
          end
        end else if (idle_q == 8'(LOCK_TIMEOUT - 1)) begin
          state_d    = UNLOCKED;
          idle_d     = '0;
          rr_d       = next_idx(owner_q);
          lock_err_d = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    if (!rst_ni) gnt_vld = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      rr_q       <= '0;
      owner_q    <= '0;
      idle_q     <= '0;
      resp_idx_q <= '0;
      resp_vld_q <= 1'b0;
      rdata_q    <= '0;
      lock_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      idle_q     <= idle_d;
      resp_vld_q <= gnt_vld;
      resp_idx_q <= gnt_idx;
      lock_err_q <= lock_err_d;
      if (gnt_vld) rdata_q <= we_i[gnt_idx] ? 64'd0 : rdata_i;
    end
  end

  assign gnt_o      = gnt_vld ? (NR_REQ'(1) << gnt_idx) : '0;
  assign en_o       = gnt_vld;
  assign we_o       = gnt_vld & we_i[gnt_idx];
  assign address_o  = gnt_vld ? addr_i[gnt_idx] : '0;
  assign wdata_o    = gnt_vld ? wdata_i[gnt_idx] : '0;
  assign rvalid_o   = resp_vld_q ? (NR_REQ'(1) << resp_idx_q) : '0;
  assign rdata_o    = rdata_q;
  assign lock_err_o = lock_err_q;

endmodule

// File: tb/tb_timer_port_arbiter.sv
// Directed and randomized checks of timer_port_arbiter against a cycle-level
// reference model built from the arbitration and locking rules.
module tb_timer_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int LT = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NR-1:0]           req, we, lock;
  logic [NR-1:0][AW-1:0]   addr;
  logic [NR-1:0][63:0]     wdata;
  logic [63:0]             rdata_in;
  logic [NR-1:0]           gnt, rvalid;
  logic [63:0]             rdata_out, wdata_out;
  logic                    lock_err, en, we_out;
  logic [AW-1:0]           address;

  timer_port_arbiter #(.NR_REQ(NR), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(LT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata_out), .lock_err_o(lock_err), .en_o(en), .we_o(we_out),
    .address_o(address), .wdata_o(wdata_out), .rdata_i(rdata_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lock ownership, quiet-cycle count since the owner's last
  // access, next-in-line pointer, and the response owed for the next cycle.
  bit          m_locked;
  int          m_owner, m_quiet, m_next;
  bit          m_pend;
  int          m_pend_idx;
  logic [63:0] m_rdata;
  bit          m_err;

  logic [NR-1:0] last_gnt, last_rvalid;
  logic [63:0]   last_rdata;
  logic          last_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_quiet = 0; m_next = 0;
    m_pend = 0; m_pend_idx = 0; m_rdata = '0; m_err = 0;
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int i = 0; i < NR; i++)
      if (req[(m_next + i) % NR]) return (m_next + i) % NR;
    return -1;
  endfunction

  task automatic model_update(input int g);
    m_err  = 0;
    m_pend = (g >= 0);
    if (g >= 0) begin
      m_pend_idx = g;
      m_rdata    = we[g] ? 64'd0 : rdata_in;
      if (!m_locked) m_next = (g + 1) % NR;
      m_quiet = 0;
      if (lock[g]) begin
        m_locked = 1; m_owner = g;
      end else if (m_locked) begin
        m_locked = 0; m_next = (g + 1) % NR;
      end
    end else if (m_locked) begin
      m_quiet++;
      if (m_quiet == LT) begin
        m_locked = 0; m_quiet = 0; m_next = (m_owner + 1) % NR; m_err = 1;
      end
    end
  endtask

  // One clock cycle: inputs already applied just after the edge; compare
  // mid-cycle, advance the model, then move to just after the next edge.
  task automatic tick();
    int            g;
    logic [NR-1:0] e_gnt;
    #3;
    if (!rst_n) model_reset();
    g     = model_grant();
    e_gnt = (g >= 0) ? (NR'(1) << g) : '0;
    last_gnt = gnt; last_rvalid = rvalid; last_rdata = rdata_out; last_err = lock_err;
    check("gnt", gnt, e_gnt);
    check("en", en, g >= 0);
    check("we", we_out, (g >= 0) ? we[g] : 1'b0);
    check("address", address, (g >= 0) ? addr[g] : '0);
    check("wdata", wdata_out, (g >= 0) ? wdata[g] : '0);
    check("rvalid", rvalid, m_pend ? (NR'(1) << m_pend_idx) : '0);
    check("rdata", rdata_out, m_rdata);
    check("lock_err", lock_err, m_err);
    if (rst_n) model_update(g);
    @(posedge clk); #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) begin
      addr[i]  = {$urandom, $urandom};
      wdata[i] = {$urandom, $urandom};
    end
    rdata_in = {$urandom, $urandom};
  endtask

  initial begin
    logic [NR-1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    rst_n = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0; rdata_in = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset holds everything quiet even with requests pending.
    req = 2'b11; lock = 2'b11; rand_data();
    tick();
    check("rst_gnt", last_gnt, 2'b00);
    check("rst_err", last_err, 1'b0);
    tick();
    rst_n = 1'b1; req = '0; lock = '0;
    tick();

    // Round-robin between two constant requesters.
    req = 2'b11; we = 2'b00;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick();
      check("rr_gnt", last_gnt, seq[i]);
      if (i > 0) check("rr_rvalid", last_rvalid, seq[i-1]);
    end

    // Read from requester 0.
    req = 2'b01; we = 2'b00; addr[0] = 64'hC00; rdata_in = 64'h1234;
    tick();
    check("rd_gnt", last_gnt, 2'b01);
    req = 2'b00; rdata_in = 64'hDEAD;
    tick();
    check("rd_rvalid", last_rvalid, 2'b01);
    check("rd_rdata", last_rdata, 64'h1234);

    // Requester 1 takes the lock with a write, holds it, then releases.
    req = 2'b10; we = 2'b10; lock = 2'b10; addr[1] = 64'h400; wdata[1] = 64'h55;
    tick();
    check("lk_gnt0", last_gnt, 2'b10);
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lk_gnt_hold", last_gnt, 2'b10);
    end
    lock = 2'b00;
    tick();
    check("lk_release", last_gnt, 2'b10);
    tick();
    check("lk_after", last_gnt, 2'b01);
    check("lk_wr_rdata", last_rdata, 64'd0);

    // Requester 0 locks then goes idle; the lock times out.
    req = 2'b01; we = 2'b00; lock = 2'b01; rand_data();
    tick();
    check("to_lock", last_gnt, 2'b01);
    req = 2'b10; lock = 2'b00;
    for (int k = 1; k <= LT + 1; k++) begin
      tick();
      if (k <= LT) begin
        check("to_stall", last_gnt, 2'b00);
        check("to_noerr", last_err, 1'b0);
      end
    end
    check("to_err", last_err, 1'b1);
    check("to_gnt1", last_gnt, 2'b10);
    req = 2'b00;
    tick();
    check("to_err_clr", last_err, 1'b0);

    // Randomized traffic, first dense then sparse enough to provoke timeouts.
    for (int c = 0; c < 300; c++) begin
      req = NR'($urandom); we = NR'($urandom);
      for (int i = 0; i < NR; i++) lock[i] = ($urandom_range(0, 3) == 0);
      rand_data();
      tick();
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        req[i]  = ($urandom_range(0, 7) == 0);
        lock[i] = ($urandom_range(0, 1) == 0);
      end
      we = NR'($urandom);
      rand_data();
      tick();
    end

    // Reset while locked with a response pending.
    req = 2'b00; lock = 2'b00;
    for (int i = 0; i < LT + 2; i++) tick();
    req = 2'b10; lock = 2'b10; we = 2'b00; rand_data();
    tick();
    check("mr_lock", last_gnt, 2'b10);
    rst_n = 1'b0; req = 2'b11; lock = 2'b11;
    tick();
    check("mr_gnt", last_gnt, 2'b00);
    check("mr_rvalid", last_rvalid, 2'b00);
    check("mr_rdata", last_rdata, 64'd0);
    rst_n = 1'b1; lock = 2'b00;
    tick();
    check("mr_first", last_gnt, 2'b01);
    check("mr_noerr", last_err, 1'b0);
    req = 2'b00;
    tick();
    check("mr_rvalid2", last_rvalid, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
